rs_dec_out_framer: RTL
======================

Name: rs_dec_out_framer

Overview:
- Sits directly downstream of the RS(16,8) decoder and consumes its corrected-symbol stream (symb_out_val, symb_out_cnt, symb_corrected).
- Strips the N-K parity symbols of each codeword and buffers the K message symbols in a small FIFO.
- Re-emits the message symbols as a framed valid/ready stream with sop/eop. Because the decoder cannot be stalled, the block also detects index-sequence errors and buffer overflow.

Parameters:
- N, 16, codeword length in symbols
- K, 8, message symbols per codeword (indices 0..K-1 are data; K..N-1 are parity)
- DEPTH, 16, FIFO entries (power of two, >= K)
- AW, 4, log2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- symb_out_val  input  1  decoder output symbol valid
- symb_out_cnt  input  8  decoder output symbol index within codeword, 0..N-1
- symb_corrected  input  8  decoder corrected symbol
- dout_rdy  input  1  downstream ready
- dout_val  output  1  output symbol valid
- dout_sop  output  1  first message symbol of codeword
- dout_eop  output  1  last message symbol of codeword
- dout  output  8  message symbol
- seq_err  output  1  one-cycle pulse: index discontinuity detected
- ovf  output  1  one-cycle pulse: symbol dropped, FIFO full
- fill  output  AW+1  current FIFO occupancy

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n is low, all state clears asynchronously: pointers 0, fill 0, expected index 0, FSM IDLE. Outputs during and after reset: dout_val=0, dout_sop=0, dout_eop=0, dout=0, seq_err=0, ovf=0, fill=0. Reset mid-frame discards all buffered symbols; no partial frame is emitted afterwards.
- Input FSM states are IDLE, DATA and PARITY, tracking exp_cnt (8-bit). Only cycles with symb_out_val=1 advance it.
  - IDLE: cnt==0 writes the symbol, sets exp_cnt=1 and moves to DATA. Any other cnt pulses seq_err, writes nothing and stays in IDLE.
  - DATA: cnt==exp_cnt writes the symbol. When cnt==K-1, move to PARITY and set exp_cnt=K; otherwise exp_cnt++.
  - PARITY: cnt==exp_cnt is dropped, not written. When cnt==N-1, move to IDLE and set exp_cnt=0.
  - Mismatch in DATA or PARITY: pulse seq_err the next cycle. Then resync: cnt==0 is handled as in IDLE (the new frame starts). Any other cnt goes to IDLE and is dropped. Data already in the FIFO from the aborted frame is still emitted; its final entry carries no eop.
- Each FIFO entry is 10 bits: {sop, eop, data}. sop = (cnt==0); eop = (cnt==K-1).
- Write rule: a write occurs when the FSM selects the symbol and the FIFO is not full, or it is full and a read happens in the same cycle. Otherwise the symbol is dropped and ovf pulses the next cycle. The FSM advances regardless of a drop.
- Read side is show-ahead:
  - dout_val = (fill != 0); dout, dout_sop and dout_eop are taken from mem[rd_ptr].
  - A read happens when dout_val && dout_rdy.
  - dout_val, dout and the tags must hold stable while dout_val && !dout_rdy.
- Latency: a symbol accepted at edge t appears on dout after edge t (first cycle it can be read), provided it is at the head of the FIFO.
- Simultaneous read and write: fill is unchanged; legal when full or empty. An empty FIFO with a write and dout_rdy=1 does not bypass; dout_val rises the next cycle.
- Pointers are AW bits and wrap modulo DEPTH. fill is AW+1 bits, so full = (fill==DEPTH).
- seq_err and ovf are registered, one cycle wide, and may assert in the same cycle.

Decomposition:
- Shared package rs_16_8_pkg holds N, K, symbol width 8, and the localparam FSM encodings (IDLE, DATA, PARITY).
- Sub-module rs_sym_fifo: sync FIFO, show-ahead, width 10, depth DEPTH, with full/empty/fill outputs. The FSM, tagging and error pulses stay in rs_dec_out_framer.

Test Plan:
- Single codeword with cnt 0..15 and data = cnt+0x10, dout_rdy=1 -> exactly 8 outputs 0x10..0x17; sop on 0x10, eop on 0x17; seq_err=0, ovf=0; fill returns to 0.
- Three back-to-back codewords (48 valid cycles), dout_rdy held 0 for 40 cycles -> FIFO fills at 16 and the 8 symbols of codeword 3 are dropped with 8 ovf pulses. After release, 16 outputs are emitted with 2 sop/eop pairs.
- Index jump: cnt sequence 0,1,2,5 -> seq_err pulses once; 3 symbols emitted (sop on first, no eop). A following clean 0..15 codeword is emitted normally.
- Restart mid-frame: cnt 0..3 then 0..15 -> one seq_err; 4+8 outputs with two sops, one eop.
- Stall with dout_rdy toggling 1/0 each cycle during a codeword -> dout stable whenever dout_rdy=0; order preserved; no loss.
- rst_n asserted with fill=5 and mid-DATA -> outputs go to 0 immediately; after release a clean codeword yields exactly 8 outputs.

Source files
------------

// File: rtl/rs_16_8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : rs_16_8_pkg                                                   |
// | Purpose    : Shared constants and types for the RS(16,8) decoder output    |
// |              framer: code geometry, symbol width, input FSM encoding and   |
// |              the tagged FIFO entry layout.                                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package rs_16_8_pkg;

  localparam int N     = 16;         // codeword length in symbols
  localparam int K     = 8;          // message symbols per codeword
  localparam int SYM_W = 8;          // symbol width in bits

  // Input-side FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } fsm_state_t;

  // One FIFO entry: frame tags ahead of the message symbol
  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [SYM_W-1:0] data;
  } fifo_ent_t;

endpackage : rs_16_8_pkg
`default_nettype wire

// File: rtl/rs_dec_out_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : rs_dec_out_framer_if                                          |
// | Purpose    : Bundles the decoder symbol stream, the framed output stream   |
// |              and the status outputs of rs_dec_out_framer.                  |
// | Signals    : symb_out_val/cnt, symb_corrected  - decoder symbol stream     |
// |              dout_val/rdy/sop/eop, dout        - framed message stream     |
// |              seq_err, ovf, fill                - status                    |
// | Modports   : slave  - the framer                                           |
// |              master - the environment (decoder + downstream sink)          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface rs_dec_out_framer_if #(
  parameter int AW = 4
);
  import rs_16_8_pkg::*;

  logic             symb_out_val;
  logic [7:0]       symb_out_cnt;
  logic [SYM_W-1:0] symb_corrected;
  logic             dout_rdy;
  logic             dout_val;
  logic             dout_sop;
  logic             dout_eop;
  logic [SYM_W-1:0] dout;
  logic             seq_err;
  logic             ovf;
  logic [AW:0]      fill;

  modport slave (
    input  symb_out_val, symb_out_cnt, symb_corrected, dout_rdy,
    output dout_val, dout_sop, dout_eop, dout, seq_err, ovf, fill
  );

  modport master (
    output symb_out_val, symb_out_cnt, symb_corrected, dout_rdy,
    input  dout_val, dout_sop, dout_eop, dout, seq_err, ovf, fill
  );

endinterface : rs_dec_out_framer_if
`default_nettype wire

// File: rtl/rs_sym_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rs_sym_fifo                                                   |
// | Purpose    : Synchronous show-ahead FIFO. The head entry is always visible |
// |              on o_rd_data; i_rd_en pops it.                                |
// | Ports      : clk, rst_n            - clock, async active-low reset         |
// |              i_wr_en, i_wr_data    - push request and data                 |
// |              i_rd_en               - pop request                           |
// |              o_rd_data             - head entry                            |
// |              o_full, o_empty, o_fill - occupancy status                    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rs_sym_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_wr_en,
  input  wire logic [WIDTH-1:0] i_wr_data,
  input  wire logic             i_rd_en,
  output logic      [WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic      [AW:0]      o_fill
);

  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;

  logic w_rd;
  logic w_wr;

  // A push into a full FIFO is accepted only when a pop frees the slot in the
  // same cycle; a pop of an empty FIFO is ignored.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Storage is not reset; the read side qualifies it with occupancy.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_fill == c_FULL);
  assign o_empty   = (r_fill == '0);
  assign o_fill    = r_fill;

endmodule : rs_sym_fifo
`default_nettype wire

// File: rtl/rs_dec_out_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rs_dec_out_framer                                             |
// | Purpose    : Consumes the RS(16,8) decoder corrected-symbol stream, strips |
// |              parity symbols, buffers the message symbols and re-emits them |
// |              as a sop/eop framed valid/ready stream. Flags index sequence  |
// |              errors and symbols dropped on FIFO overflow.                  |
// | Ports      : clk    - system clock, rising edge                            |
// |              rst_n  - asynchronous active-low reset                        |
// |              bus    - rs_dec_out_framer_if.slave (decoder stream in,       |
// |                       framed stream out, seq_err/ovf pulses, fill)         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rs_dec_out_framer #(
  parameter int N     = rs_16_8_pkg::N,
  parameter int K     = rs_16_8_pkg::K,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rs_dec_out_framer_if.slave bus
);
  import rs_16_8_pkg::*;

  localparam logic [7:0] c_K_M1 = 8'(K - 1);
  localparam logic [7:0] c_N_M1 = 8'(N - 1);
  localparam logic [7:0] c_K    = 8'(K);

  fsm_state_t r_state;
  fsm_state_t w_state_nxt;
  logic [7:0] r_exp_cnt;
  logic [7:0] w_exp_nxt;
  logic       r_seq_err;
  logic       r_ovf;

  logic       w_sel;     // FSM wants this symbol stored
  logic       w_err;     // index discontinuity on this symbol
  logic       w_rd;
  logic       w_wr;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  fifo_ent_t  w_wr_ent;
  fifo_ent_t  w_rd_ent;

  // --------------------------------------------------------------------------
  // Input FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_exp_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp_cnt <= w_exp_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Input FSM: next state, expected index and symbol selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp_cnt;
    w_sel       = 1'b0;
    w_err       = 1'b0;

    if (bus.symb_out_val) begin
      if (r_state != ST_IDLE && bus.symb_out_cnt == r_exp_cnt) begin
        // In-sequence symbol of the current frame
        if (r_state == ST_DATA) begin
          w_sel = 1'b1;
          if (bus.symb_out_cnt == c_K_M1) begin
            w_state_nxt = ST_PARITY;
            w_exp_nxt   = c_K;
          end else begin
            w_exp_nxt   = r_exp_cnt + 8'd1;
          end
        end else if (bus.symb_out_cnt == c_N_M1) begin
          w_state_nxt = ST_IDLE;
          w_exp_nxt   = '0;
        end else begin
          w_exp_nxt   = r_exp_cnt + 8'd1;
        end
      end else if (bus.symb_out_cnt == 8'd0) begin
        // Frame start; out of IDLE it also means the previous frame was cut
        // short, which is an error but the new frame is taken immediately.
        w_err       = (r_state != ST_IDLE);
        w_sel       = 1'b1;
        w_state_nxt = ST_DATA;
        w_exp_nxt   = 8'd1;
      end else begin
        // Unexpected index: drop it and wait for the next frame start
        w_err       = 1'b1;
        w_state_nxt = ST_IDLE;
        w_exp_nxt   = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO write gating. The decoder cannot be stalled, so a selected symbol
  // that finds no room is lost and reported.
  // --------------------------------------------------------------------------
  assign w_rd   = !w_empty && bus.dout_rdy;
  assign w_wr   = w_sel && (!w_full || w_rd);
  assign w_drop = w_sel && !w_wr;

  assign w_wr_ent.sop  = (bus.symb_out_cnt == 8'd0);
  assign w_wr_ent.eop  = (bus.symb_out_cnt == c_K_M1);
  assign w_wr_ent.data = bus.symb_corrected;

  rs_sym_fifo #(
    .WIDTH (SYM_W + 2),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr),
    .i_wr_data (w_wr_ent),
    .i_rd_en   (w_rd),
    .o_rd_data (w_rd_ent),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_fill    (bus.fill)
  );

  // --------------------------------------------------------------------------
  // Status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_seq_err <= w_err;
      r_ovf     <= w_drop;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Unread storage is masked so the stream reads zero when empty.
  // --------------------------------------------------------------------------
  assign bus.dout_val = !w_empty;
  assign bus.dout     = w_empty ? '0   : w_rd_ent.data;
  assign bus.dout_sop = w_empty ? 1'b0 : w_rd_ent.sop;
  assign bus.dout_eop = w_empty ? 1'b0 : w_rd_ent.eop;
  assign bus.seq_err  = r_seq_err;
  assign bus.ovf      = r_ovf;

endmodule : rs_dec_out_framer
`default_nettype wire
